// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial transmit path: arbiter FSM state
//   encodings, the 12 MHz clock rate and the default stall timeout (1 ms).
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int CLK_HZ        = 12_000_000;
    // One millisecond of clk12 cycles: how long a granted source may leave the
    // transmitter waiting for its next byte before it loses the grant.
    localparam int STALL_CYC_DEF = CLK_HZ / 1000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority encoder. Scans req starting at index
//   ptr, then ptr+1, ... wrapping modulo N_REQ, and returns the first set index.
// Ports
//   req  in   N_REQ  request vector
//   ptr  in   ID_W   index with highest priority this pick
//   any  out  1      at least one request is set
//   idx  out  ID_W   chosen index (0 when any=0)
// -----------------------------------------------------------------------------
module rr_pick
    import serial_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    int j;

    // Walk the scan order from last to first so the lowest scan offset that
    // hits is the one left standing.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                any = 1'b1;
                idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
//   Shares one serial_tx byte transmitter between N_REQ message sources.
//   Whole messages are granted (bytes up to and including the one flagged
//   last), requesters are served round-robin, and a source that stalls
//   mid-message for STALL_CYC cycles is released with a stall_err pulse.
// Ports
//   clk12      in   1        12 MHz clock, all logic on posedge
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   N_REQ    requester i presents a byte
//   req_data   in   8*N_REQ  requester i byte at [8i+7:8i]
//   req_last   in   N_REQ    presented byte ends the message
//   req_ack    out  N_REQ    1-cycle pulse: byte of requester i taken
//   tx_byte    out  8        byte to serial_tx, held until the next load
//   tx_start   out  1        1-cycle start pulse to serial_tx
//   tx_done    in   1        1-cycle end-of-send pulse from serial_tx
//   busy       out  1        a message is granted
//   grant_id   out  ID_W     granted requester, valid while busy
//   stall_err  out  1        1-cycle pulse on a timeout release
// -----------------------------------------------------------------------------
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int STALL_CYC = STALL_CYC_DEF
) (
    input  logic               clk12,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [7:0]         tx_byte,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               stall_err
);

    localparam int CNT_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;

    state_t           state;
    state_t           state_nx;
    logic [ID_W-1:0]  rr_ptr;
    logic             last_r;
    logic [CNT_W-1:0] stall_cnt;

    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;
    logic             grant_valid;
    logic             cnt_at_end;

    logic             do_grant;
    logic             do_load;
    logic             do_release;
    logic             stall_fire;

    // Pointer moves just past the requester that held the grant, so a lone
    // requester is still re-picked at once (the scan skips empty slots).
    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] g);
        if (g == ID_W'(N_REQ - 1)) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Only the granted requester is ever looked at once a message is underway.
    assign grant_valid = req_valid[grant_id];
    assign cnt_at_end  = (stall_cnt == CNT_W'(STALL_CYC - 1));

    // State register
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_nx = ST_ARB;
                end
            end
            ST_ARB: begin
                // A request that vanished between IDLE and ARB just falls back.
                state_nx = pick_any ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                state_nx = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_nx = last_r ? ST_IDLE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (grant_valid) begin
                    state_nx = ST_LOAD;
                end else if (cnt_at_end) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Output/control decode
    always_comb begin
        do_grant   = (state == ST_ARB) && pick_any;
        do_load    = (state == ST_LOAD);
        stall_fire = (state == ST_NEXT) && !grant_valid && cnt_at_end;
        do_release = ((state == ST_WAIT_DONE) && tx_done && last_r) || stall_fire;
    end

    // Registered outputs, byte/last holding registers and stall counter.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            tx_byte   <= 8'h00;
            last_r    <= 1'b0;
            tx_start  <= 1'b0;
            req_ack   <= '0;
            stall_err <= 1'b0;
            stall_cnt <= '0;
        end else begin
            // ack and start leave together, one cycle after the byte is captured
            tx_start  <= do_load;
            req_ack   <= do_load ? (N_REQ'(1) << grant_id) : '0;
            stall_err <= stall_fire;

            if (do_grant) begin
                grant_id <= pick_idx;
                busy     <= 1'b1;
            end

            if (do_load) begin
                tx_byte <= req_data[8*grant_id +: 8];
                last_r  <= req_last[grant_id];
            end

            if (do_release) begin
                busy   <= 1'b0;
                rr_ptr <= ptr_after(grant_id);
            end

            // Counts only while parked in NEXT; any other state clears it, so
            // each wait for a new byte starts from zero.
            if ((state == ST_NEXT) && !cnt_at_end) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

endmodule
